// File: rtl/regfile_access_arbiter.sv
// Per-cycle arbiter sharing the register-file port set between the core and the debug port.
// The grant steers the winner's fields onto the register file; read data returns to the owner one cycle later.
module regfile_access_arbiter #(
  parameter int WAIT_MAX = 4,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_raddr_a,
  input  logic [AW-1:0] core_raddr_b,
  input  logic [AW-1:0] core_waddr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata_a,
  output logic [DW-1:0] core_rdata_b,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_raddr_a,
  input  logic [AW-1:0] dbg_raddr_b,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata_a,
  output logic [DW-1:0] dbg_rdata_b,
  output logic [AW-1:0] rf_addA,
  output logic [AW-1:0] rf_addB,
  output logic [AW-1:0] rf_addD,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  input  logic [DW-1:0] rf_dataA,
  input  logic [DW-1:0] rf_dataB,
  output logic          dbg_starved
);

  typedef enum logic [1:0] {CORE_PRI, DBG_FORCED, DBG_LOCKED} pri_mode_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

  localparam logic [3:0] WAIT_FULL = 4'(WAIT_MAX);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  pri_mode_t pri_mode, pri_mode_nxt;
  owner_t    owner;
  logic [3:0] wait_cnt;
  logic       dbg_denied;

  assign dbg_denied  = dbg_req & ~dbg_gnt;
  assign dbg_starved = (wait_cnt == WAIT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_mode <= CORE_PRI;
    else     pri_mode <= pri_mode_nxt;
  end

  // Grants are gated off while reset is high so nothing reaches the register file.
  always_comb begin
    core_gnt     = 1'b0;
    dbg_gnt      = 1'b0;
    pri_mode_nxt = pri_mode;
    if (!rst) begin
      unique case (pri_mode)
        CORE_PRI: begin
          core_gnt = core_req;
          dbg_gnt  = dbg_req & ~core_req;
        end
        DBG_FORCED: begin
          dbg_gnt  = dbg_req;
          core_gnt = core_req & ~dbg_req;
        end
        DBG_LOCKED: begin
          dbg_gnt  = dbg_req;
        end
        default: ;
      endcase
      unique case (pri_mode)
        CORE_PRI: begin
          if (dbg_gnt && dbg_lock)
            pri_mode_nxt = DBG_LOCKED;
          else if (dbg_req && !dbg_gnt && wait_cnt == WAIT_LAST)
            pri_mode_nxt = DBG_FORCED;
        end
        DBG_FORCED: begin
          if (dbg_gnt) pri_mode_nxt = dbg_lock ? DBG_LOCKED : CORE_PRI;
        end
        DBG_LOCKED: begin
          if (!dbg_lock) pri_mode_nxt = CORE_PRI;
        end
        default: pri_mode_nxt = CORE_PRI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= 4'd0;
    else if (dbg_denied) begin
      if (wait_cnt != WAIT_FULL) wait_cnt <= wait_cnt + 4'd1;
    end else
      wait_cnt <= 4'd0;
  end

  always_comb begin
    rf_addA  = '0;
    rf_addB  = '0;
    rf_addD  = '0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    if (core_gnt) begin
      rf_addA  = core_raddr_a;
      rf_addB  = core_raddr_b;
      rf_addD  = core_waddr;
      rf_wdata = core_wdata;
      rf_we    = core_we;
    end else if (dbg_gnt) begin
      rf_addA  = dbg_raddr_a;
      rf_addB  = dbg_raddr_b;
      rf_addD  = dbg_waddr;
      rf_wdata = dbg_wdata;
      rf_we    = dbg_we;
    end
  end

  // Every grant, write-only included, produces exactly one rvalid in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           owner <= OWN_NONE;
    else if (core_gnt) owner <= OWN_CORE;
    else if (dbg_gnt)  owner <= OWN_DBG;
    else               owner <= OWN_NONE;
  end

  assign core_rvalid  = (owner == OWN_CORE);
  assign dbg_rvalid   = (owner == OWN_DBG);
  assign core_rdata_a = core_rvalid ? rf_dataA : '0;
  assign core_rdata_b = core_rvalid ? rf_dataB : '0;
  assign dbg_rdata_a  = dbg_rvalid  ? rf_dataA : '0;
  assign dbg_rdata_b  = dbg_rvalid  ? rf_dataB : '0;

endmodule
